// File: rtl/frac_clk_div_pkg.sv
// rtl/frac_clk_div_pkg.sv - shared widths, default ratio, ratio struct and legality check
package frac_clk_div_pkg;

    localparam int DEF_INT_W     = 8;
    localparam int DEF_FRAC_W    = 8;
    localparam int DEF_RATIO_INT = 8;
    localparam int DEF_RATIO_NUM = 7;
    localparam int DEF_RATIO_DEN = 10;

    typedef struct packed {
        logic [DEF_INT_W-1:0]  int_div;
        logic [DEF_FRAC_W-1:0] num;
        logic [DEF_FRAC_W-1:0] den;
    } ratio_t;

    // Below N=2 there is no room for a high and a low phase in one period.
    function automatic logic ratio_legal(ratio_t r);
        return (r.int_div >= DEF_INT_W'(2)) && (r.den != '0) && (r.num < r.den);
    endfunction

endpackage

// File: rtl/frac_clk_div_if.sv
// rtl/frac_clk_div_if.sv - configuration valid/ready port of the fractional divider
interface frac_clk_div_if
    import frac_clk_div_pkg::*;
#(
    parameter int INT_W  = DEF_INT_W,
    parameter int FRAC_W = DEF_FRAC_W
);
    logic              cfg_valid;
    logic              cfg_ready;
    logic [INT_W-1:0]  cfg_int;
    logic [FRAC_W-1:0] cfg_num;
    logic [FRAC_W-1:0] cfg_den;
    logic              cfg_err;

    modport master (
        output cfg_valid, cfg_int, cfg_num, cfg_den,
        input  cfg_ready, cfg_err
    );

    modport slave (
        input  cfg_valid, cfg_int, cfg_num, cfg_den,
        output cfg_ready, cfg_err
    );
endinterface

// File: rtl/frac_phase_acc.sv
// rtl/frac_phase_acc.sv - first-order phase accumulator choosing N or N+1 per period
module frac_phase_acc
    import frac_clk_div_pkg::*;
#(
    parameter int FRAC_W = DEF_FRAC_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              step,
    input  logic [FRAC_W-1:0] num,
    input  logic [FRAC_W-1:0] den,
    output logic              long_period
);

    logic [FRAC_W:0] acc_q;
    logic [FRAC_W:0] acc_d;
    logic [FRAC_W:0] base;
    logic [FRAC_W:0] sum;

    // A clear coinciding with a step starts the new ratio from zero phase.
    always_comb begin
        base        = clear ? '0 : acc_q;
        sum         = base + {1'b0, num};
        long_period = (sum >= {1'b0, den});
        acc_d       = acc_q;
        if (step) begin
            acc_d = long_period ? (sum - {1'b0, den}) : sum;
        end else if (clear) begin
            acc_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/frac_clk_div.sv
// rtl/frac_clk_div.sv - fractional clock divider N+num/den; FRAC_CLK_DIV_TICK_EN adds the tick output
module frac_clk_div
    import frac_clk_div_pkg::*;
#(
    parameter int INT_W   = DEF_INT_W,
    parameter int FRAC_W  = DEF_FRAC_W,
    parameter int DEF_INT = DEF_RATIO_INT,
    parameter int DEF_NUM = DEF_RATIO_NUM,
    parameter int DEF_DEN = DEF_RATIO_DEN
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    frac_clk_div_if.slave        cfg,
    output logic                 clk_out
`ifdef FRAC_CLK_DIV_TICK_EN
    ,
    output logic                 tick
`endif
);

    localparam ratio_t RESET_RATIO = '{
        int_div: INT_W'(DEF_INT),
        num:     FRAC_W'(DEF_NUM),
        den:     FRAC_W'(DEF_DEN)
    };

    ratio_t         active_q, active_d;
    ratio_t         shadow_q, shadow_d;
    logic           shad_full_q, shad_full_d;
    logic           cfg_err_q, cfg_err_d;
    logic           clk_out_q, clk_out_d;
    logic [INT_W:0] cnt_q, cnt_d;
    logic [INT_W:0] per_q, per_d;

    logic           start;
    logic           apply;
    logic           offer;
    logic           long_period;
    ratio_t         eff;
    ratio_t         offered;
    logic [INT_W:0] period_len;
    logic [INT_W:0] phase;
    logic           in_high;

    // cnt_q counts down the cycles left in the period; zero marks the last
    // cycle, where the next period length is decided.
    assign start      = en && (cnt_q == '0);
    assign apply      = shad_full_q && (start || !en);
    assign eff        = apply ? shadow_q : active_q;
    assign offer      = cfg.cfg_valid && !shad_full_q;
    assign offered    = '{int_div: cfg.cfg_int, num: cfg.cfg_num, den: cfg.cfg_den};
    assign period_len = {1'b0, eff.int_div} + (INT_W+1)'(long_period);
    assign phase      = per_q - (INT_W+1)'(1) - cnt_q;
    assign in_high    = (per_q != '0) && (phase < (per_q >> 1));

    frac_phase_acc #(
        .FRAC_W (FRAC_W)
    ) u_phase_acc (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (apply || !en),
        .step        (start),
        .num         (eff.num),
        .den         (eff.den),
        .long_period (long_period)
    );

    always_comb begin
        active_d    = active_q;
        shadow_d    = shadow_q;
        shad_full_d = shad_full_q;
        cfg_err_d   = 1'b0;
        cnt_d       = cnt_q;
        per_d       = per_q;

        if (apply) begin
            active_d    = shadow_q;
            shad_full_d = 1'b0;
        end

        if (offer) begin
            if (ratio_legal(offered)) begin
                shadow_d    = offered;
                shad_full_d = 1'b1;
            end else begin
                cfg_err_d = 1'b1;
            end
        end

        if (!en) begin
            cnt_d = '0;
            per_d = '0;
        end else if (start) begin
            per_d = period_len;
            cnt_d = period_len - (INT_W+1)'(1);
        end else begin
            cnt_d = cnt_q - (INT_W+1)'(1);
        end

        clk_out_d = en && in_high;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q    <= RESET_RATIO;
            shadow_q    <= RESET_RATIO;
            shad_full_q <= 1'b0;
            cfg_err_q   <= 1'b0;
            clk_out_q   <= 1'b0;
            cnt_q       <= '0;
            per_q       <= '0;
        end else begin
            active_q    <= active_d;
            shadow_q    <= shadow_d;
            shad_full_q <= shad_full_d;
            cfg_err_q   <= cfg_err_d;
            clk_out_q   <= clk_out_d;
            cnt_q       <= cnt_d;
            per_q       <= per_d;
        end
    end

    assign cfg.cfg_ready = !shad_full_q;
    assign cfg.cfg_err   = cfg_err_q;
    assign clk_out       = clk_out_q;

`ifdef FRAC_CLK_DIV_TICK_EN
    logic tick_q, tick_d;

    assign tick_d = clk_out_d && !clk_out_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_q <= 1'b0;
        end else begin
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;
`endif

endmodule

// File: tb/tb_frac_clk_div.sv
// tb/tb_frac_clk_div.sv - directed self-checking bench for frac_clk_div
module tb_frac_clk_div;

    logic clk = 1'b0;
    logic rst_n;
    logic en;
    logic clk_out;
`ifdef FRAC_CLK_DIV_TICK_EN
    logic tick;
`endif

    frac_clk_div_if #(.INT_W(8), .FRAC_W(8)) cfg_if ();

    frac_clk_div dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .cfg     (cfg_if),
        .clk_out (clk_out)
`ifdef FRAC_CLK_DIV_TICK_EN
        ,
        .tick    (tick)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    int exp_87[10]  = '{8, 9, 9, 8, 9, 9, 8, 9, 9, 9};
    int exp_35[4]   = '{3, 4, 3, 4};
    int exp_rst[3]  = '{8, 9, 9};
    int bad_cfg[3][3] = '{'{4, 0, 0}, '{4, 3, 3}, '{1, 0, 1}};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input logic v, input int i, input int n, input int d);
        cfg_if.cfg_valid = v;
        cfg_if.cfg_int   = 8'(i);
        cfg_if.cfg_num   = 8'(n);
        cfg_if.cfg_den   = 8'(d);
    endtask

    task automatic sync_rise(output int n);
        logic prv;
        logic rise;
        n    = 0;
        prv  = clk_out;
        rise = 1'b0;
        while (!rise && n < 600) begin
            step();
            n++;
            rise = clk_out && !prv;
            prv  = clk_out;
        end
    endtask

    // Called on a rise sample; returns period and high count up to the next rise.
    task automatic measure(output int p, output int h);
        logic prv;
        p   = 0;
        h   = clk_out ? 1 : 0;
        prv = clk_out;
        while (p < 600) begin
            step();
            p++;
            if (clk_out && !prv) break;
            if (clk_out) h++;
            prv = clk_out;
        end
    endtask

    initial begin
        int p, h, n, tot, good, p2, h2;

        rst_n = 1'b0;
        en    = 1'b0;
        set_cfg(1'b0, 0, 0, 0);
        step();
        step();
        chk("rst_clk_out", clk_out, 0);
        chk("rst_cfg_err", cfg_if.cfg_err, 0);
        chk("rst_cfg_ready", cfg_if.cfg_ready, 1);

        en    = 1'b1;
        rst_n = 1'b1;
        step();
        chk("first_edge_c1", clk_out, 0);
        step();
        chk("first_edge_c2", clk_out, 1);
`ifdef FRAC_CLK_DIV_TICK_EN
        chk("first_tick", tick, 1);
`endif

        tot = 0;
        for (int i = 0; i < 10; i++) begin
            measure(p, h);
            chk($sformatf("d87_per%0d", i), p, exp_87[i]);
            chk($sformatf("d87_hi%0d", i), h, exp_87[i] / 2);
            tot += p;
        end
        chk("d87_total", tot, 87);

        set_cfg(1'b1, 3, 1, 2);
        chk("rc_ready_offer", cfg_if.cfg_ready, 1);
        step();
        set_cfg(1'b1, 5, 0, 1);
        chk("rc_stall0", cfg_if.cfg_ready, 0);
        step();
        chk("rc_stall1", cfg_if.cfg_ready, 0);
        step();
        chk("rc_stall2", cfg_if.cfg_ready, 0);
        set_cfg(1'b0, 0, 0, 0);
        sync_rise(n);
        chk("rc_old_full", n + 3, 8);
        chk("rc_ready_after", cfg_if.cfg_ready, 1);
        for (int i = 0; i < 4; i++) begin
            measure(p, h);
            chk($sformatf("d35_per%0d", i), p, exp_35[i]);
            chk($sformatf("d35_hi%0d", i), h, exp_35[i] / 2);
        end

        for (int k = 0; k < 3; k++) begin
            set_cfg(1'b1, bad_cfg[k][0], bad_cfg[k][1], bad_cfg[k][2]);
            step();
            set_cfg(1'b0, 0, 0, 0);
            chk($sformatf("bad%0d_err", k), cfg_if.cfg_err, 1);
            chk($sformatf("bad%0d_ready", k), cfg_if.cfg_ready, 1);
            step();
            chk($sformatf("bad%0d_err_end", k), cfg_if.cfg_err, 0);
        end
        sync_rise(n);
        measure(p, h);
        measure(p2, h2);
        chk("bad_ratio_kept", p + p2, 7);

        set_cfg(1'b1, 4, 0, 1);
        step();
        set_cfg(1'b0, 0, 0, 0);
        chk("n4_ready_low", cfg_if.cfg_ready, 0);
        sync_rise(n);
        chk("n4_ready_back", cfg_if.cfg_ready, 1);
        for (int i = 0; i < 3; i++) begin
            measure(p, h);
            chk($sformatf("n4_per%0d", i), p, 4);
            chk($sformatf("n4_hi%0d", i), h, 2);
        end

        set_cfg(1'b1, 5, 0, 1);
        step();
        set_cfg(1'b0, 0, 0, 0);
        sync_rise(n);
        good = 0;
        for (int i = 0; i < 100; i++) begin
            measure(p, h);
            if (p == 5 && h == 2) good++;
        end
        chk("n5_stable", good, 100);

        step();
        chk("en_hi_phase", clk_out, 1);
        en = 1'b0;
        step();
        chk("en_off_low", clk_out, 0);
        set_cfg(1'b1, 8, 7, 10);
        step();
        set_cfg(1'b0, 0, 0, 0);
        chk("en_off_ready0", cfg_if.cfg_ready, 0);
        step();
        chk("en_off_ready1", cfg_if.cfg_ready, 1);
        chk("en_off_still_low", clk_out, 0);
        en = 1'b1;
        step();
        chk("en_on_c1", clk_out, 0);
        step();
        chk("en_on_c2", clk_out, 1);
        for (int i = 0; i < 3; i++) begin
            measure(p, h);
            chk($sformatf("en_on_per%0d", i), p, exp_rst[i]);
        end

        set_cfg(1'b1, 4, 0, 1);
        step();
        set_cfg(1'b0, 0, 0, 0);
        chk("arst_pre_ready", cfg_if.cfg_ready, 0);
        chk("arst_pre_high", clk_out, 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_clk_out", clk_out, 0);
        chk("arst_ready", cfg_if.cfg_ready, 1);
        chk("arst_err", cfg_if.cfg_err, 0);
        step();
        rst_n = 1'b1;
        step();
        chk("arst_rel_c1", clk_out, 0);
        step();
        chk("arst_rel_c2", clk_out, 1);
        measure(p, h);
        chk("arst_default_per", p, 8);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/frac_clk_div.md
# frac_clk_div

Runtime-programmable fractional clock divider: produces `clk_out` with an average period of N + num/den input cycles. Each output period is N or N+1 cycles, chosen by a first-order phase accumulator, with near-50% duty per period. It generalises the fixed dual-modulus divider to arbitrary integer/fraction ratios, adds an enable, and supports glitch-free reconfiguration through a valid/ready port. It sits in the clock-generation area and drives low-rate derived clocks and strobes.

## Interface
- `INT_W`, 8: width of integer divisor N.
- `FRAC_W`, 8: width of numerator and denominator.
- `DEF_INT`, 8: N after reset.
- `DEF_NUM`, 7: numerator after reset.
- `DEF_DEN`, 10: denominator after reset. Defaults give 8.7.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `en` in 1: divider enable.
- `cfg_valid` in 1: new configuration offered.
- `cfg_ready` out 1: shadow register empty; configuration can be accepted.
- `cfg_int` in INT_W: N.
- `cfg_num` in FRAC_W: numerator.
- `cfg_den` in FRAC_W: denominator.
- `cfg_err` out 1: one-cycle pulse when a rejected configuration is offered.
- `clk_out` out 1: divided clock, registered.

## Operation
- Reset values:
  - `clk_out`=0, `cfg_err`=0, `cfg_ready`=1.
  - Active configuration = DEF_*.
  - Accumulator = 0, period counter = 0.
  - Shadow register empty.
- The accumulator is FRAC_W+1 bits wide. Invariant: acc < den.
- At each period start (counter == 0, en=1):
  - acc' = acc + num.
  - If acc' ≥ den: P = N+1 and acc = acc' − den. Otherwise P = N and acc = acc'.
- Phase within the period runs c = 0..P−1. The output is high for c < (P>>1) and low for the rest. Example: P=9 gives 4 high and 5 low; P=8 gives 4/4.
- Legal configuration is N ≥ 2, den ≠ 0, num < den.
- Handshake:
  - A transfer occurs on cycle with `cfg_valid`&&`cfg_ready`.
  - A legal configuration goes into the shadow register and `cfg_ready` drops to 0.
  - An illegal configuration is dropped and `cfg_err` pulses in the next cycle. `cfg_ready` stays 1.
- Apply:
  - The shadow configuration becomes active at the next period start, or on the next cycle if en=0.
  - Apply clears acc to 0 and sets `cfg_ready`=1 in the same cycle.
- If `cfg_valid` and a period start coincide, the existing shadow is applied first. The new offer is stalled because `cfg_ready`=0.
- When en=0:
  - The counter and accumulator clear to 0.
  - `clk_out` goes to 0 on the next cycle.
  - The handshake remains functional.
- When en returns to 1, a fresh period starts with acc=0.
- num=0 gives an exact integer divide by N.

## Timing
- `clk_out` has one-cycle latency from the counter state. The first rising edge appears on the second posedge after reset release with en=1.
- The period-start decision and accumulator update happen in the same cycle; there are no bubbles between periods.
- Reconfiguration never shortens or truncates the current period. There are no runt pulses.
- Asserting `rst_n` mid-period returns all outputs to their reset values asynchronously.
- Worst-case apply latency is N_old+1 cycles after acceptance.

## Configuration
- `FRAC_CLK_DIV_TICK_EN`:
  - Defined: adds output port `tick` (1 bit, reset 0). `tick` is a one-cycle pulse registered alongside the rising edge of `clk_out`, i.e. high on exactly the cycles where `clk_out` transitions 0→1. Use it as a clock-enable in the `clk` domain.
  - Undefined: the port and its logic are absent. All other behaviour is identical.

## Structure
- Package `frac_clk_div_pkg` holds:
  - Default widths and default ratio constants.
  - A config-legality function.
  - A packed struct for {int, num, den} used by the shadow and active registers.
- Sub-module `frac_phase_acc` contains the accumulator and the N/N+1 decision. Interface: clk, rst_n, clear, step, num, den → long_period.
- The top level holds the period counter, duty compare, handshake, and shadow/active registers.

## Test plan
- Default 8.7, en=1 after reset: 87 cycles contain 10 rising edges. Period sequence is 8,9,9,8,9,9,8,9,9,9, then repeats.
- Configure N=4, num=0, den=1: steady 2-high/2-low square wave. `cfg_ready` is low from acceptance until the current period ends.
- Configure N=5, num=0: each period is 2 high, 3 low. Duty is stable over 100 periods.
- Offer den=0, then num=den=3, then N=1: `cfg_err` pulses once per offer, the active ratio is unchanged, and `cfg_ready` stays 1.
- Reconfigure mid-period from 8.7 to 3.5 (num=1, den=2): the current period completes at full length, then periods run 3,4,3,4. A second offer while `cfg_ready`=0 stalls.
- Drop en mid-high-phase, then assert `rst_n` low mid-period: `clk_out` reads 0 the next cycle; after re-enable the sequence restarts from the first period; reset forces all outputs to their reset values immediately.
